wide_split_sched: RTL and testbench



---
 rtl/wide_split_pkg.sv | 13 +
 rtl/wide_split_sched_rr_arb2.sv | 13 +
 rtl/wide_split_sched.sv | 114 +++++++++++
 tb/tb_wide_split_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wide_split_pkg.sv
// Shared types and widths for the wide-word splitter: beat/word widths and FSM state encoding.
package wide_split_pkg;
  localparam int LW = 45;
  localparam int DW = 90;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  typedef logic [LW-1:0] beat_t;
endpackage

// File: rtl/wide_split_sched_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, the requester that did not win last time has priority.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  // last==1 means requester 1 won previously, so requester 0 has priority now
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end
endmodule

// File: rtl/wide_split_sched.sv
// Arbitrates two 90-bit requesters onto one 45-bit line, sending upper half then lower half.
// Optional macro WIDE_SPLIT_PARITY_EN adds the line_par output (even parity of line_data).
module wide_split_sched
  import wide_split_pkg::*;
#(
  parameter int DW = wide_split_pkg::DW,
  parameter int LW = wide_split_pkg::LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          line_valid,
  input  logic          line_ready,
  output logic [LW-1:0] line_data,
  output logic          line_last,
  output logic          line_src,
  output logic          busy
`ifdef WIDE_SPLIT_PARITY_EN
  ,
  output logic          line_par
`endif
);

  generate
    if (DW != 2 * LW) begin : g_width_check
      $error("wide_split_sched: DW must equal 2*LW");
    end
  endgenerate

  // Handshake: a transfer happens on a cycle where valid and ready are both high;
  // reqN_ready is only offered in IDLE, line beats advance only when line_ready is high.
  state_t        state, state_nx;
  logic [DW-1:0] hold;
  logic          src;
  logic          last_grant;
  logic [1:0]    gnt;
  logic          take;

  rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (last_grant),
    .gnt  (gnt)
  );

  always_comb begin
    state_nx   = state;
    take       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = gnt[0];
        req1_ready = gnt[1];
        if (|gnt) begin
          take     = 1'b1;
          state_nx = HI;
        end
      end
      HI:      if (line_ready) state_nx = LO;
      LO:      if (line_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      src        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (take) begin
        hold       <= gnt[1] ? req1_data : req0_data;
        src        <= gnt[1];
        last_grant <= gnt[1];
      end
    end
  end

  // Line outputs are pure decodes of the registered state, so async reset clears them instantly.
  always_comb begin
    line_valid = 1'b0;
    line_data  = '0;
    line_last  = 1'b0;
    line_src   = 1'b0;
    case (state)
      HI: begin
        line_valid = 1'b1;
        line_data  = hold[DW-1:LW];
        line_src   = src;
      end
      LO: begin
        line_valid = 1'b1;
        line_data  = hold[LW-1:0];
        line_last  = 1'b1;
        line_src   = src;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef WIDE_SPLIT_PARITY_EN
  assign line_par = line_valid & (^line_data);
`endif

endmodule

// File: tb/tb_wide_split_sched.sv
// Directed bench for wide_split_sched: table of single-word transfers plus stall and reset sequences.
module tb_wide_split_sched;
  localparam int DW = 90;
  localparam int LW = 45;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          line_valid, line_ready;
  logic [LW-1:0] line_data;
  logic          line_last, line_src, busy;
`ifdef WIDE_SPLIT_PARITY_EN
  logic          line_par;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  wide_split_sched #(.DW(DW), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .line_last  (line_last),
    .line_src   (line_src),
    .busy       (busy)
`ifdef WIDE_SPLIT_PARITY_EN
    ,
    .line_par   (line_par)
`endif
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " idle line_valid"}, DW'(line_valid), DW'(1'b0));
    chk({tag, " idle busy"}, DW'(busy), DW'(1'b0));
    chk({tag, " idle line_data"}, DW'(line_data), DW'(0));
`ifdef WIDE_SPLIT_PARITY_EN
    chk({tag, " idle line_par"}, DW'(line_par), DW'(1'b0));
`endif
  endtask

  task automatic chk_beat(input string tag, input logic [LW-1:0] exp_d, input logic exp_last,
                          input logic exp_src);
    chk({tag, " line_valid"}, DW'(line_valid), DW'(1'b1));
    chk({tag, " line_data"}, DW'(line_data), DW'(exp_d));
    chk({tag, " line_last"}, DW'(line_last), DW'(exp_last));
    chk({tag, " line_src"}, DW'(line_src), DW'(exp_src));
    chk({tag, " busy"}, DW'(busy), DW'(1'b1));
    chk({tag, " no ready"}, DW'({req1_ready, req0_ready}), DW'(2'b00));
`ifdef WIDE_SPLIT_PARITY_EN
    chk({tag, " line_par"}, DW'(line_par), DW'(^exp_d));
`endif
  endtask

  typedef struct {
    logic          v0;
    logic          v1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          exp_src;
    logic [LW-1:0] exp_hi;
    logic [LW-1:0] exp_lo;
    logic          chk_period;
  } vec_t;

  vec_t vecs[9];
  int   prev_acc;

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    line_ready = 1'b0;
    prev_acc   = 0;

    // both requesting from reset: strict alternation starting with req0
    vecs[0] = '{1'b1, 1'b1, 90'h1, 90'h2, 1'b0, 45'h0, 45'h1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 90'h1, 90'h2, 1'b1, 45'h0, 45'h2, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 90'h1, 90'h2, 1'b0, 45'h0, 45'h1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 90'h1, 90'h2, 1'b1, 45'h0, 45'h2, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 90'h3FFFFFFFFFFFFFFFFFFFFFF, 90'h0, 1'b0,
                45'h1FFFFFFFFFFF, 45'h1FFFFFFFFFFF, 1'b0};
    // req1 alone, three back-to-back words at one word per 3 cycles
    vecs[5] = '{1'b0, 1'b1, 90'h0, {45'h0ABCDE, 45'h01234}, 1'b1, 45'h0ABCDE, 45'h01234, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 90'h0, {45'h1F0F0F0F0F0F, 45'h00000000000F}, 1'b1,
                45'h1F0F0F0F0F0F, 45'h00000000000F, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 90'h0, {45'h100000000000, 45'h1FFFFFFFFFFE}, 1'b1,
                45'h100000000000, 45'h1FFFFFFFFFFE, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 90'h2AAAAAAAAAAAAAAAAAAAAAA, 90'h3, 1'b0,
                45'h155555555555, 45'h0AAAAAAAAAAA, 1'b0};

    // reset values
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset ready", DW'({req1_ready, req0_ready}), DW'(2'b00));
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post-reset");

    // table-driven single-word transfers
    line_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req0_valid = vecs[i].v0;
      req1_valid = vecs[i].v1;
      req0_data  = vecs[i].d0;
      req1_data  = vecs[i].d1;
      #1;
      chk($sformatf("v%0d grant", i), DW'({req1_ready, req0_ready}),
          DW'(vecs[i].exp_src ? 2'b10 : 2'b01));
      if (vecs[i].chk_period) chk($sformatf("v%0d period", i), DW'(cyc - prev_acc), DW'(3));
      prev_acc = cyc;
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk_beat($sformatf("v%0d hi", i), vecs[i].exp_hi, 1'b0, vecs[i].exp_src);
      @(negedge clk);
      #1;
      chk_beat($sformatf("v%0d lo", i), vecs[i].exp_lo, 1'b1, vecs[i].exp_src);
      @(negedge clk);
      chk_idle($sformatf("v%0d", i));
    end

    // stall in HI for 5 cycles, then release
    req1_valid = 1'b1;
    req1_data  = {45'h123456789AB, 45'h0FEDCBA9876};
    line_ready = 1'b0;
    #1;
    chk("stall grant", DW'({req1_ready, req0_ready}), DW'(2'b10));
    @(negedge clk);
    req1_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_beat($sformatf("stall hi %0d", k), 45'h123456789AB, 1'b0, 1'b1);
      @(negedge clk);
    end
    line_ready = 1'b1;
    #1;
    chk_beat("stall hi release", 45'h123456789AB, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk_beat("stall lo", 45'h0FEDCBA9876, 1'b1, 1'b1);
    @(negedge clk);
    chk_idle("stall");

    // reset asserted while the LO beat is waiting
    req0_valid = 1'b1;
    req0_data  = 90'h2AAAAAAAAAAAAAAAAAAAAAA;
    #1;
    chk("rst grant", DW'({req1_ready, req0_ready}), DW'(2'b01));
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk_beat("rst hi", 45'h155555555555, 1'b0, 1'b0);
    @(negedge clk);
    line_ready = 1'b0;
    #1;
    chk_beat("rst lo", 45'h0AAAAAAAAAAA, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst line_valid drop", DW'(line_valid), DW'(1'b0));
    chk("rst busy drop", DW'(busy), DW'(1'b0));
    @(negedge clk);
    rst_n      = 1'b1;
    line_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_idle($sformatf("rst after %0d", k));
    end

    // after reset, both valid again: req0 wins
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 90'h1;
    req1_data  = 90'h2;
    #1;
    chk("rst rearb", DW'({req1_ready, req0_ready}), DW'(2'b01));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk_beat("rearb hi", 45'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk_beat("rearb lo", 45'h1, 1'b1, 1'b0);
    @(negedge clk);
    chk_idle("rearb");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end
endmodule
